// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Optional auto-repeat is enabled with the KEY_AUTOREPEAT_EN macro.
package key_cond_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } key_state_t;

    // Board defaults at 50 MHz: 20 ms debounce, 0.5 s repeat delay, 0.1 s repeat period
    localparam int DEF_N_KEYS          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, registered pulses.
// With KEY_AUTOREPEAT_EN defined, a held key re-pulses key press periodically.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int CNT_W           = 21,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    // Board keys are active-low; s is 1 while the key is pressed
    assign s = ~sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync_q    <= {sync_q[0], key_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

`ifdef KEY_AUTOREPEAT_EN
        // Timer only runs while the key stays in PRESSED; anywhere else it rearms
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        if (state_q == ST_PRESSED && s) begin
            rpt_first_d = rpt_first_q;
            if (rpt_cnt_q == (rpt_first_q ? RD_LAST : RP_LAST)) begin
                press_d     = 1'b1;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
            end
        end
`endif
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Multi-key push-button conditioner: one independent debounce channel per key.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat press pulses on held keys.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clock_50,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    // Extra bit of headroom so a saturated counter never aliases a compare value
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clock_50 (clock_50),
            .reset_n  (reset_n),
            .key_i    (key_in[g]),
            .level_o  (key_level[g]),
            .press_o  (key_press[g]),
            .release_o(key_release[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a per-cycle run-length model of the
// debounce/repeat rules plus hand-computed cycle checks.
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clock_50 = 1'b0;
    logic         reset_n  = 1'b0;
    logic [N-1:0] key_in   = '1;
    logic [N-1:0] key_level, key_press, key_release;

    int errors = 0;
    int checks = 0;

    key_conditioner #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #10 clock_50 = ~clock_50;

    // Model: s is the pressed sample delayed two edges; a level flip needs D+1
    // consecutive samples of the new level, repeats fire on absolute edge numbers.
    int           cyc = 0;
    bit           m_valid = 0;
    logic [N-1:0] m_p1, m_p2, m_prev_s, m_level, m_press, m_rel;
    int           run_p [N];
    int           run_r [N];
    int           next_rep [N];

    always @(posedge clock_50) begin
        cyc++;
        if (!reset_n) begin
            m_p1 = '0; m_p2 = '0; m_prev_s = '0;
            m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N; i++) begin
                run_p[i] = 0; run_r[i] = 0; next_rep[i] = -1;
            end
            m_valid = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic s;
                s = m_p2[i];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (s) begin
                    if (run_p[i] < 1000) run_p[i]++;
                    run_r[i] = 0;
                end else begin
                    if (run_r[i] < 1000) run_r[i]++;
                    run_p[i] = 0;
                end
                if (!m_level[i] && run_p[i] >= D + 1) begin
                    m_level[i] = 1'b1;
                    m_press[i] = 1'b1;
                    next_rep[i] = cyc + RD;
                end else if (m_level[i] && run_r[i] >= D + 1) begin
                    m_level[i] = 1'b0;
                    m_rel[i]   = 1'b1;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (m_level[i] && s) begin
                    if (!m_prev_s[i]) next_rep[i] = cyc + RD;
                    else if (cyc == next_rep[i]) begin
                        m_press[i] = 1'b1;
                        next_rep[i] = cyc + RP;
                    end
                end
`endif
                m_prev_s[i] = s;
            end
            m_p2 = m_p1;
            m_p1 = ~key_in;
        end
    end

    always @(negedge clock_50) begin
        if (m_valid) begin
            checks++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL model cyc=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                         cyc, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    initial begin
        int npress;

        // Reset state
        tick(3);
        chk("reset_level", key_level, 4'b0000);
        chk("reset_press", key_press, 4'b0000);
        chk("reset_release", key_release, 4'b0000);
        reset_n = 1'b1;
        tick(3);

        // Clean press on key 1, release at cycle 20
        key_in[1] = 1'b0;
        tick(6);
        chk("clean_press_c5", key_press, 4'b0000);
        tick(1);
        chk("clean_press_c6", key_press, 4'b0010);
        chk("clean_level_c6", key_level, 4'b0010);
        tick(1);
        chk("clean_press_c7", key_press, 4'b0000);
        tick(12);
        key_in[1] = 1'b1;
        tick(6);
        chk("release_c25", key_release, 4'b0000);
        chk("release_lvl_c25", key_level, 4'b0010);
        tick(1);
        chk("release_c26", key_release, 4'b0010);
        chk("release_lvl_c26", key_level, 4'b0000);
        tick(3);

        // Bounce on key 2
        key_in[2] = 1'b0;
        tick(3);
        key_in[2] = 1'b1;
        tick(1);
        key_in[2] = 1'b0;
        tick(6);
        chk("bounce_c9", key_press, 4'b0000);
        tick(1);
        chk("bounce_c10", key_press, 4'b0100);
        key_in[2] = 1'b1;
        tick(10);

        // Reset in the middle of a debounce on key 3
        key_in[3] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("rst_mid_level", key_level, 4'b0000);
        tick(6);
        chk("rst_mid_c10", key_press, 4'b0000);
        tick(1);
        chk("rst_mid_c11", key_press, 4'b1000);
        key_in[3] = 1'b1;
        tick(10);

        // Parallel press and release on keys 0 and 3
        key_in = 4'b0110;
        tick(7);
        chk("par_press", key_press, 4'b1001);
        chk("par_level", key_level, 4'b1001);
        key_in = 4'b1111;
        tick(7);
        chk("par_release", key_release, 4'b1001);
        tick(3);

        // Boundary: pressed run one short of acceptance, then exactly enough
        key_in[0] = 1'b0;
        tick(4);
        key_in[0] = 1'b1;
        npress = 0;
        repeat (10) begin
            tick(1);
            if (key_press[0]) npress++;
        end
        chk("short_run_no_press", 4'(npress), 4'd0);
        key_in[0] = 1'b0;
        tick(5);
        key_in[0] = 1'b1;
        tick(2);
        chk("exact_run_press", key_press, 4'b0001);
        tick(10);

        // Held key: one press, or press at 6 then repeats at 16,19,22,25,28
        key_in[1] = 1'b0;
        npress = 0;
        repeat (30) begin
            tick(1);
            if (key_press[1]) npress++;
        end
`ifdef KEY_AUTOREPEAT_EN
        chk("hold_press_count", 4'(npress), 4'd6);
`else
        chk("hold_press_count", 4'(npress), 4'd1);
`endif
        chk("hold_level", key_level, 4'b0010);
        key_in[1] = 1'b1;
        tick(10);

        // Random bounce traffic on all channels, checked by the model
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) key_in[i] = ~key_in[i];
            tick(1);
        end
        key_in = '1;
        tick(12);
        chk("final_level", key_level, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range >= 1.
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles from the initial press pulse to the first repeat pulse (0.5 s); legal range >= 1.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses (0.1 s); legal range >= 1.
REQ-005 clock_50  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 key_in  input  N_KEYS  raw asynchronous board keys, active-low (0 = pressed).
REQ-008 key_level  output  N_KEYS  debounced key state, active-high (1 = pressed).
REQ-009 key_press  output  N_KEYS  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-010 key_release  output  N_KEYS  one-cycle pulse per accepted release.

Function
REQ-011 Each channel SHALL be independent; behaviour below is per bit i.
REQ-012 key_in[i] SHALL pass through a two-flop synchronizer, then be inverted to give sample s (1 = pressed).
REQ-013 Channel FSM SHALL have states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED, s=1 -> PRESS_WAIT with counter cleared; RELEASED, s=0 -> stay.
REQ-015 PRESS_WAIT: counter increments each cycle s=1; s=0 -> RELEASED, counter cleared, no pulse (bounce rejected).
REQ-016 PRESS_WAIT -> PRESSED when s=1 has held DEBOUNCE_CYCLES consecutive cycles; key_level[i] rises and key_press[i] pulses in the same cycle.
REQ-017 PRESSED/RELEASE_WAIT SHALL mirror REQ-014..016 with s inverted; entering RELEASED drops key_level[i] and pulses key_release[i].
REQ-018 Latency: a key_in edge stable from cycle 0 SHALL produce its key_press/key_release pulse at cycle DEBOUNCE_CYCLES+2, exactly.
REQ-019 All outputs SHALL be registered; pulses exactly one cycle wide; key_press and key_release never both high on one channel.
REQ-020 Counters SHALL saturate, never wrap; width = $clog2 of the largest parameter, +1.
REQ-021 Simultaneous events on different channels SHALL be handled in the same cycle without interaction.

Reset
REQ-022 While reset_n=0 at a clock edge: synchronizer flops = 1 (released), FSMs = RELEASED, counters = 0, key_level = 0, key_press = 0, key_release = 0.
REQ-023 Reset mid-debounce or mid-press SHALL abort with no pulse; a key held through reset release SHALL produce a normal key_press after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-024 Macro KEY_AUTOREPEAT_EN defined: in PRESSED, key_press[i] SHALL pulse again REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles, until PRESSED is left; repeat timer clears on leaving PRESSED.
REQ-025 Macro KEY_AUTOREPEAT_EN undefined: exactly one key_press pulse per accepted press; REPEAT_* parameters unused; no repeat timer logic synthesized.

Structure
REQ-026 Package key_cond_pkg SHALL hold the FSM state enum type (key_state_t) and default timing constants.
REQ-027 Per-channel logic SHALL be sub-module key_debounce_ch, instantiated N_KEYS times via generate; top holds no FSM logic.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=4)
REQ-028 Clean press: key_in[1] 1->0 at cycle 0, held -> key_press[1] high at cycle 6 only, key_level[1] high from cycle 6.
REQ-029 Bounce: key_in[2] low cycles 0-2, high cycle 3, low from 4 -> no pulse before cycle 10; single key_press[2] at cycle 10.
REQ-030 Release: after REQ-028, key_in[1] 0->1 at cycle 20 -> key_release[1] at cycle 26, key_level[1] low from 26.
REQ-031 Reset mid-debounce: reset_n low at cycle 4 of a press, released cycle 5, key held -> no pulse before cycle 11, key_press at cycle 11.
REQ-032 Auto-repeat (macro defined): key held, press pulse at cycle 6 -> key_press at 16, 19, 22, ...; macro undefined -> only cycle 6.
REQ-033 Parallel keys: key_in[0] and key_in[3] fall same cycle -> both key_press pulses in the same cycle, other channels idle.
